// File: rtl/hps_reset_req_seq.sv
// hps_reset_req_seq: turns rising edges on the ISSP reset-source bus into
// fixed-width active-low HPS reset requests, served one at a time in
// cold > warm > debug order, with HPS handshake tracking and a holdoff.
module hps_reset_req_seq #(
    parameter int unsigned PULSE_CYCLES   = 16,
    parameter int unsigned HOLDOFF_CYCLES = 1024,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [2:0] issp_src,
    input  logic       h2f_reset_n,
    output logic       f2h_cold_reset_req_n,
    output logic       f2h_warm_reset_req_n,
    output logic       f2h_debug_reset_req_n,
    output logic       busy,
    output logic [1:0] last_req,
    output logic [7:0] req_count,
    output logic       hs_timeout
);

    localparam int unsigned MAX_CNT = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLDOFF_CYCLES - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ASSERT    = 3'd1;
    localparam logic [2:0] S_WAIT_LOW  = 3'd2;
    localparam logic [2:0] S_WAIT_HIGH = 3'd3;
    localparam logic [2:0] S_HOLDOFF   = 3'd4;

    localparam logic [1:0] REQ_COLD  = 2'd1;
    localparam logic [1:0] REQ_WARM  = 2'd2;
    localparam logic [1:0] REQ_DEBUG = 2'd3;

    logic [2:0]             issp_sync_q [SYNC_STAGES];
    logic [2:0]             issp_hist_q;
    logic [SYNC_STAGES-1:0] h2f_sync_q;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       pend_q, pend_d;
    logic [1:0]       last_req_q, last_req_d;
    logic [7:0]       req_count_q, req_count_d;
    logic             hs_timeout_q, hs_timeout_d;
    logic             busy_q, busy_d;
    logic [2:0]       req_n_q, req_n_d;

    logic [2:0] rise_c;
    logic [2:0] drop_c;
    logic       h2f_c;

    // Synchronizer chains for the asynchronous inputs plus edge history.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                issp_sync_q[i] <= 3'b000;
            end
            issp_hist_q <= 3'b000;
            h2f_sync_q  <= '0;
        end else begin
            issp_sync_q[0] <= issp_src;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                issp_sync_q[i] <= issp_sync_q[i-1];
            end
            issp_hist_q <= issp_sync_q[SYNC_STAGES-1];
            h2f_sync_q  <= {h2f_sync_q[SYNC_STAGES-2:0], h2f_reset_n};
        end
    end

    assign rise_c = issp_sync_q[SYNC_STAGES-1] & ~issp_hist_q;
    assign h2f_c  = h2f_sync_q[SYNC_STAGES-1];

    // Edge of the request type currently being pulsed is discarded.
    always_comb begin
        drop_c = 3'b000;
        if (state_q == S_ASSERT) begin
            case (last_req_q)
                REQ_COLD:  drop_c = 3'b001;
                REQ_WARM:  drop_c = 3'b010;
                REQ_DEBUG: drop_c = 3'b100;
                default:   drop_c = 3'b000;
            endcase
        end
    end

    // State, counter and all output registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            pend_q       <= 3'b000;
            last_req_q   <= 2'd0;
            req_count_q  <= 8'd0;
            hs_timeout_q <= 1'b0;
            busy_q       <= 1'b0;
            req_n_q      <= 3'b111;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            last_req_q   <= last_req_d;
            req_count_q  <= req_count_d;
            hs_timeout_q <= hs_timeout_d;
            busy_q       <= busy_d;
            req_n_q      <= req_n_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so the
    // request lines come straight from flops.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        last_req_d   = last_req_q;
        req_count_d  = req_count_q;
        hs_timeout_d = hs_timeout_q;
        busy_d       = 1'b0;
        req_n_d      = 3'b111;

        case (state_q)
            S_IDLE: begin
                if (pend_q != 3'b000) begin
                    state_d = S_ASSERT;
                    cnt_d   = PULSE_LOAD;
                    if (pend_q[0]) begin
                        last_req_d = REQ_COLD;
                        pend_d[0]  = 1'b0;
                    end else if (pend_q[1]) begin
                        last_req_d = REQ_WARM;
                        pend_d[1]  = 1'b0;
                    end else begin
                        last_req_d = REQ_DEBUG;
                        pend_d[2]  = 1'b0;
                    end
                    if (req_count_q != 8'hFF) begin
                        req_count_d = req_count_q + 8'd1;
                    end
                end
            end
            S_ASSERT: begin
                if (cnt_q == '0) begin
                    cnt_d   = HOLD_LOAD;
                    state_d = (last_req_q == REQ_DEBUG) ? S_HOLDOFF : S_WAIT_LOW;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WAIT_LOW: begin
                if (!h2f_c) begin
                    state_d = S_WAIT_HIGH;
                end else if (cnt_q == '0) begin
                    hs_timeout_d = 1'b1;
                    state_d      = S_HOLDOFF;
                    cnt_d        = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (h2f_c) begin
                    state_d = S_HOLDOFF;
                    cnt_d   = HOLD_LOAD;
                end
            end
            S_HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        pend_d = pend_d | (rise_c & ~drop_c);
        busy_d = (state_d != S_IDLE);

        if (state_d == S_ASSERT) begin
            case (last_req_d)
                REQ_COLD:  req_n_d[0] = 1'b0;
                REQ_WARM:  req_n_d[1] = 1'b0;
                REQ_DEBUG: req_n_d[2] = 1'b0;
                default:   req_n_d    = 3'b111;
            endcase
        end
    end

    assign f2h_cold_reset_req_n  = req_n_q[0];
    assign f2h_warm_reset_req_n  = req_n_q[1];
    assign f2h_debug_reset_req_n = req_n_q[2];
    assign busy                  = busy_q;
    assign last_req              = last_req_q;
    assign req_count             = req_count_q;
    assign hs_timeout            = hs_timeout_q;

endmodule

// File: tb/tb_hps_reset_req_seq.sv
// Self-checking bench for hps_reset_req_seq: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_hps_reset_req_seq;

    localparam int unsigned PULSE = 4;
    localparam int unsigned HOLD  = 8;
    localparam int unsigned SYNC  = 2;

    localparam logic [2:0] P_IDLE  = 3'd0;
    localparam logic [2:0] P_PULSE = 3'd1;
    localparam logic [2:0] P_WLOW  = 3'd2;
    localparam logic [2:0] P_WHIGH = 3'd3;
    localparam logic [2:0] P_HOLD  = 3'd4;

    typedef struct packed {
        logic [2:0]            phase;
        logic [15:0]           left;
        logic [1:0]            cur;
        logic [1:0]            last;
        logic [7:0]            cnt;
        logic [2:0]            pend;
        logic                  hs;
        logic [3*(SYNC+2)-1:0] ih;
        logic [SYNC+1:0]       hh;
    } model_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] issp_src = 3'b000;
    logic       h2f_reset_n = 1'b1;
    logic       cold_n, warm_n, debug_n, busy;
    logic [1:0] last_req;
    logic [7:0] req_count;
    logic       hs_timeout;

    int     checks = 0;
    int     errors = 0;
    model_t m = '0;

    hps_reset_req_seq #(
        .PULSE_CYCLES  (PULSE),
        .HOLDOFF_CYCLES(HOLD),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk_clk              (clk),
        .reset_reset_n        (rst_n),
        .issp_src             (issp_src),
        .h2f_reset_n          (h2f_reset_n),
        .f2h_cold_reset_req_n (cold_n),
        .f2h_warm_reset_req_n (warm_n),
        .f2h_debug_reset_req_n(debug_n),
        .busy                 (busy),
        .last_req             (last_req),
        .req_count            (req_count),
        .hs_timeout           (hs_timeout)
    );

    always #5 clk = ~clk;

    // One clock of the reference: phases described by their remaining length.
    function automatic model_t model_next(input model_t s, input logic [2:0] src, input logic h2f);
        model_t     n;
        logic [2:0] rise;
        logic [2:0] drop;
        logic       hsync;
        n = s;
        n.ih  = {s.ih[3*(SYNC+1)-1:0], src};
        n.hh  = {s.hh[SYNC:0], h2f};
        for (int b = 0; b < 3; b++) begin
            rise[b] = n.ih[3*SYNC+b] & ~n.ih[3*(SYNC+1)+b];
        end
        hsync = n.hh[SYNC];
        drop  = 3'b000;
        if (s.phase == P_PULSE) drop[int'(s.cur)-1] = 1'b1;
        case (s.phase)
            P_IDLE: begin
                if (s.pend != 3'b000) begin
                    if (s.pend[0])      n.cur = 2'd1;
                    else if (s.pend[1]) n.cur = 2'd2;
                    else                n.cur = 2'd3;
                    n.pend[int'(n.cur)-1] = 1'b0;
                    n.last  = n.cur;
                    if (s.cnt != 8'd255) n.cnt = s.cnt + 8'd1;
                    n.phase = P_PULSE;
                    n.left  = 16'(PULSE);
                end
            end
            P_PULSE: begin
                n.left = s.left - 16'd1;
                if (n.left == 16'd0) begin
                    n.phase = (s.cur == 2'd3) ? P_HOLD : P_WLOW;
                    n.left  = 16'(HOLD);
                end
            end
            P_WLOW: begin
                if (!hsync) begin
                    n.phase = P_WHIGH;
                end else begin
                    n.left = s.left - 16'd1;
                    if (n.left == 16'd0) begin
                        n.hs    = 1'b1;
                        n.phase = P_HOLD;
                        n.left  = 16'(HOLD);
                    end
                end
            end
            P_WHIGH: begin
                if (hsync) begin
                    n.phase = P_HOLD;
                    n.left  = 16'(HOLD);
                end
            end
            default: begin
                n.left = s.left - 16'd1;
                if (n.left == 16'd0) n.phase = P_IDLE;
            end
        endcase
        n.pend = n.pend | (rise & ~drop);
        return n;
    endfunction

    // Expected {req_n[2:0], busy, last_req, req_count, hs_timeout}.
    function automatic logic [14:0] model_out(input model_t s);
        logic [2:0] rq;
        rq = 3'b111;
        if (s.phase == P_PULSE) rq[int'(s.cur)-1] = 1'b0;
        return {rq, (s.phase != P_IDLE), s.last, s.cnt, s.hs};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_next(m, issp_src, h2f_reset_n);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        issp_src = 3'b000;
        h2f_reset_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle();
        int  n;
        logic late;
        late = 1'b0;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) late = 1'b1;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) late = 1'b1;
        check("wait_idle_timeout", 32'(late), 32'd0);
    endtask

    task automatic debug_req();
        issp_src[2] = 1'b1;
        repeat (2) @(negedge clk);
        issp_src[2] = 1'b0;
        wait_idle();
    endtask

    initial begin
        logic [14:0] act;
        int  first, lows, busy_n, hs_first, lo_from, n;
        logic [2:0] prev, now;
        logic any_low;
        int  seq[$];

        rst_n = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (rst_n === 1'b1) begin
                    act = {debug_n, warm_n, cold_n, busy, last_req, req_count, hs_timeout};
                    checks++;
                    if (act !== model_out(m)) begin
                        errors++;
                        $display("FAIL model t=%0t dut=%h exp=%h", $time, act, model_out(m));
                    end
                    checks++;
                    if ($countones(~act[14:12]) > 1) begin
                        errors++;
                        $display("FAIL onehot t=%0t req_n=%b expected at most one low", $time, act[14:12]);
                    end
                end
            end
        join_none

        // Reset sanity with toggling sources.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            issp_src = 3'($urandom);
            #1;
            check("reset_hold", {24'd0, debug_n, warm_n, cold_n, busy, req_count},
                  {24'd0, 3'b111, 1'b0, 8'd0});
        end
        issp_src = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_state", {17'd0, debug_n, warm_n, cold_n, busy, last_req, req_count, hs_timeout},
              {17'd0, 3'b111, 1'b0, 2'd0, 8'd0, 1'b0});

        // Warm request with full HPS handshake.
        issp_src = 3'b010;
        first = -1; lows = 0; busy_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (c == 0) issp_src = 3'b000;
            if (!warm_n) begin lows++; if (first < 0) first = c; end
            if (busy) busy_n++;
            h2f_reset_n = (c >= 8 && c < 13) ? 1'b0 : 1'b1;
        end
        check("warm_latency", 32'(first), 32'd3);
        check("warm_width", 32'(lows), 32'd4);
        check("warm_busy_cycles", 32'(busy_n), 32'd21);
        check("warm_last_req", 32'(last_req), 32'd2);
        check("warm_req_count", 32'(req_count), 32'd1);
        check("warm_no_timeout", 32'(hs_timeout), 32'd0);

        // Cold request that the HPS never acknowledges.
        do_reset();
        issp_src = 3'b001;
        first = -1; hs_first = -1; busy_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (c == 0) issp_src = 3'b000;
            if (!cold_n && first < 0) first = c;
            if (hs_timeout && hs_first < 0) hs_first = c;
            if (busy) busy_n++;
        end
        check("timeout_latency", 32'(first), 32'd3);
        check("timeout_set_cycle", 32'(hs_first), 32'd15);
        check("timeout_busy_cycles", 32'(busy_n), 32'd20);
        check("timeout_sticky", 32'(hs_timeout), 32'd1);

        // All three sources at once, HPS answering each cold/warm request.
        do_reset();
        issp_src = 3'b111;
        prev = 3'b111; lo_from = -100;
        for (int c = 0; c < 120; c++) begin
            @(posedge clk); #1;
            if (c == 0) issp_src = 3'b000;
            now = {debug_n, warm_n, cold_n};
            for (int b = 0; b < 3; b++) begin
                if (prev[b] && !now[b]) seq.push_back(b + 1);
                if (!prev[b] && now[b] && b < 2) lo_from = c + 2;
            end
            prev = now;
            h2f_reset_n = (c >= lo_from && c < lo_from + 5) ? 1'b0 : 1'b1;
        end
        check("simul_pulses", 32'(seq.size()), 32'd3);
        if (seq.size() == 3) begin
            check("simul_order", 32'((seq[0] << 8) | (seq[1] << 4) | seq[2]), 32'h123);
        end
        check("simul_count", 32'(req_count), 32'd3);
        check("simul_last", 32'(last_req), 32'd3);
        check("simul_no_timeout", 32'(hs_timeout), 32'd0);
        check("simul_idle", 32'(busy), 32'd0);

        // Reset in the middle of a cold pulse.
        do_reset();
        issp_src = 3'b001;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (cold_n !== 1'b0 && n < 10);
        check("midrst_pulse_seen", 32'(cold_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_async", {28'd0, cold_n, busy, req_count[1:0]}, {28'd0, 1'b1, 1'b0, 2'd0});
        issp_src = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        any_low = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (!cold_n || !warm_n || !debug_n) any_low = 1'b1;
        end
        check("midrst_no_resume", 32'(any_low), 32'd0);
        check("midrst_count", 32'(req_count), 32'd0);

        // Re-trigger of debug during its own pulse is dropped, then saturation.
        do_reset();
        issp_src[2] = 1'b1;
        n = 0;
        while (debug_n !== 1'b0 && n < 10) begin @(negedge clk); n++; end
        issp_src[2] = 1'b0;
        @(negedge clk);
        issp_src[2] = 1'b1;
        @(negedge clk);
        issp_src[2] = 1'b0;
        wait_idle();
        repeat (8) @(negedge clk);
        check("drop_same_type", 32'(req_count), 32'd1);
        for (int i = 0; i < 299; i++) debug_req();
        check("saturate_count", 32'(req_count), 32'd255);
        check("saturate_last", 32'(last_req), 32'd3);

        // Randomized traffic against the model, with one asynchronous reset.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(9) == 0) issp_src[b] = ~issp_src[b];
            end
            if ($urandom_range(5) == 0) h2f_reset_n = ~h2f_reset_n;
            if (c == 1500) begin
                @(posedge clk);
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
